// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store controller driving a req/gnt/rvalid word memory.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        pipeline request handshake (ready only in IDLE)
//   req_opcode/addr/wdata      MIPS memory opcode, byte address, right-justified store data
//   mem_req/we/be/addr/wdata   memory request, held until mem_gnt
//   mem_gnt/rvalid/rdata       memory grant, read-data valid, read word
//   ld_valid/word/shift/opcode load result pulse plus held raw word, byte offset, opcode
//   st_done                    store granted pulse
//   stall                      transaction in flight
//   err_valid/err_code         error pulse: 01 misaligned, 10 bus timeout
//
// Build option: MISALIGN_TRAP_EN traps misaligned halfword/word accesses with
// err_code 01 and issues no memory request; when undefined, the offending low
// address bits are cleared and the access proceeds normally.
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [5:0]  req_opcode,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        ld_valid,
   output logic [31:0] ld_word,
   output logic [1:0]  ld_shift,
   output logic [5:0]  ld_opcode,
   output logic        st_done,
   output logic        stall,
   output logic        err_valid,
   output logic [1:0]  err_code
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);
   state_t      state, state_nx;
   logic [15:0] cnt;
   logic [5:0]  op_r;
   logic [1:0]  shift_r, sz, lo;
   logic [3:0]  be_nx;
   logic [31:0] wd_nx;
   logic        is_mem, accept, trap, go, busy, tmo, tmo_hit;
`ifdef MISALIGN_TRAP_EN
   logic        mis;
`endif
   always_comb begin
      sz     = req_opcode[1:0];
      is_mem = req_opcode inside {6'b100000, 6'b100001, 6'b100011, 6'b100100,
                                  6'b100101, 6'b101000, 6'b101001, 6'b101011};
      accept = req_valid && req_ready && is_mem;
`ifdef MISALIGN_TRAP_EN
      mis    = (sz == 2'b01 && req_addr[0]) || (sz == 2'b11 && req_addr[1:0] != 2'b00);
      trap   = accept && mis;
      lo     = req_addr[1:0];
`else
      // Misaligned accesses are silently realigned down to their natural boundary.
      trap   = 1'b0;
      lo     = sz == 2'b01 ? {req_addr[1], 1'b0} : sz == 2'b11 ? 2'b00 : req_addr[1:0];
`endif
      go     = accept && !trap;
      be_nx  = !req_opcode[3] ? 4'hf : sz == 2'b00 ? 4'b0001 << lo :
               sz == 2'b01 ? (lo[1] ? 4'b1100 : 4'b0011) : 4'hf;
      wd_nx  = !req_opcode[3] ? 32'h0 : sz == 2'b00 ? {4{req_wdata[7:0]}} :
               sz == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
      busy   = state == ISSUE || state == WAIT;
      // The terminal cycle is the one in which the counter would reach TIMEOUT_CYCLES.
      tmo    = busy && (cnt + 16'd1 == TMO);
      // Completion on the terminal cycle wins; a granted load still lacking data times out.
      tmo_hit = tmo && !(state == ISSUE ? mem_gnt && (mem_we || mem_rvalid) : mem_rvalid);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = go ? ISSUE : IDLE;
         ISSUE:   state_nx = mem_gnt && mem_we ? IDLE : mem_gnt && mem_rvalid ? RESP :
                             tmo ? IDLE : mem_gnt ? WAIT : ISSUE;
         WAIT:    state_nx = mem_rvalid ? RESP : tmo ? IDLE : WAIT;
         default: state_nx = IDLE;
      endcase
   end
   always_comb begin
      req_ready = state == IDLE;
      stall     = state != IDLE;
      mem_req   = state == ISSUE;
      ld_valid  = state == RESP;
      st_done   = state == ISSUE && mem_gnt && mem_we;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt       <= '0;
         mem_addr  <= '0;
         mem_be    <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
         op_r      <= '0;
         shift_r   <= '0;
         ld_word   <= '0;
         ld_shift  <= '0;
         ld_opcode <= '0;
         err_valid <= 1'b0;
         err_code  <= '0;
      end else begin
         cnt <= go ? 16'd0 : busy ? cnt + 16'd1 : cnt;
         if (go) begin
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_be    <= be_nx;
            mem_we    <= req_opcode[3];
            mem_wdata <= wd_nx;
            op_r      <= req_opcode;
            shift_r   <= lo;
         end
         if (state_nx == RESP) begin
            ld_word   <= mem_rdata;
            ld_shift  <= shift_r;
            ld_opcode <= op_r;
         end
         err_valid <= trap || tmo_hit;
         err_code  <= trap ? 2'b01 : tmo_hit ? 2'b10 : 2'b00;
      end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized and directed checks of mem_access_unit against a transaction-level model.
module tb_mem_access_unit;
   localparam int T = 8;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        req_valid = 1'b0, req_valid4 = 1'b0;
   logic [5:0]  req_opcode = '0;
   logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
   logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
   logic        req_ready, mem_req, mem_we, ld_valid, st_done, stall, err_valid;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata, ld_word;
   logic [1:0]  ld_shift, err_code;
   logic [5:0]  ld_opcode;
   logic        req_ready4, mem_req4, mem_we4, ld_valid4, st_done4, stall4, err_valid4;
   logic [3:0]  mem_be4;
   logic [31:0] mem_addr4, mem_wdata4, ld_word4;
   logic [1:0]  ld_shift4, err_code4;
   logic [5:0]  ld_opcode4;
   int          errors = 0, checks = 0;
   logic        chk = 1'b0;
   logic        e_ready, e_stall, e_req, e_ldv, e_std, e_errv, e_we;
   logic [1:0]  e_code, e_shift = '0;
   logic [3:0]  e_be;
   logic [31:0] e_addr, e_wd, e_word = '0;
   logic [5:0]  e_op = '0;
   int          k, std_k, ldv_n, ldv_k;
   logic        cap_ok, cap_we, busy_m, stall_gap;
   logic [3:0]  cap_be;
   logic [31:0] cap_addr, cap_wd;
   logic [1:0]  err_c;
   logic [5:0]  ops [8] = '{6'b100000, 6'b100001, 6'b100011, 6'b100100,
                            6'b100101, 6'b101000, 6'b101001, 6'b101011};

   always #5 clk = ~clk;

   mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_opcode(req_opcode), .req_addr(req_addr), .req_wdata(req_wdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .ld_valid(ld_valid), .ld_word(ld_word), .ld_shift(ld_shift), .ld_opcode(ld_opcode),
      .st_done(st_done), .stall(stall), .err_valid(err_valid), .err_code(err_code));

   mem_access_unit #(.TIMEOUT_CYCLES(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid4), .req_ready(req_ready4),
      .req_opcode(req_opcode), .req_addr(req_addr), .req_wdata(req_wdata),
      .mem_req(mem_req4), .mem_we(mem_we4), .mem_be(mem_be4), .mem_addr(mem_addr4),
      .mem_wdata(mem_wdata4), .mem_gnt(1'b0), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .ld_valid(ld_valid4), .ld_word(ld_word4), .ld_shift(ld_shift4), .ld_opcode(ld_opcode4),
      .st_done(st_done4), .stall(stall4), .err_valid(err_valid4), .err_code(err_code4));

   task automatic ck(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk)
      if (chk) begin
         ck("req_ready", 32'(req_ready), 32'(e_ready));
         ck("stall", 32'(stall), 32'(e_stall));
         ck("mem_req", 32'(mem_req), 32'(e_req));
         ck("ld_valid", 32'(ld_valid), 32'(e_ldv));
         ck("st_done", 32'(st_done), 32'(e_std));
         ck("err_valid", 32'(err_valid), 32'(e_errv));
         if (e_errv) ck("err_code", 32'(err_code), 32'(e_code));
         if (e_req) begin
            ck("mem_addr", mem_addr, e_addr);
            ck("mem_be", 32'(mem_be), 32'(e_be));
            ck("mem_wdata", mem_wdata, e_wd);
            ck("mem_we", 32'(mem_we), 32'(e_we));
         end
         ck("ld_word", ld_word, e_word);
         ck("ld_shift", 32'(ld_shift), 32'(e_shift));
         ck("ld_opcode", 32'(ld_opcode), 32'(e_op));
      end

   task automatic idle_exp();
      e_ready = 1'b1; e_stall = 1'b0; e_req = 1'b0; e_ldv = 1'b0;
      e_std = 1'b0; e_errv = 1'b0; e_code = 2'b00;
   endtask

   task automatic cyc();
      @(negedge clk);
      if (mem_req && !cap_ok) begin
         cap_ok = 1'b1; cap_addr = mem_addr; cap_be = mem_be; cap_wd = mem_wdata; cap_we = mem_we;
      end
      if (st_done) std_k = k;
      if (ld_valid) begin ldv_n++; ldv_k = k; end
      if (err_valid) err_c = err_code;
      if (busy_m && !stall) stall_gap = 1'b1;
      k++;
      @(posedge clk); #1;
   endtask

   // One transaction: g ISSUE cycles without grant precede the grant, read data
   // follows the grant by d cycles (0 = same cycle), all within a T-cycle budget.
   task automatic run(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rd, input int g, input int d);
      int n, lo_i, code;
      logic st, trap;
      logic [1:0] o;
      st = op[3];
      n = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
      lo_i = int'(a[1:0]);
`ifdef MISALIGN_TRAP_EN
      trap = (lo_i % n) != 0;
      o = a[1:0];
`else
      trap = 1'b0;
      o = 2'(lo_i - lo_i % n);
`endif
      e_addr = {a[31:2], 2'b00};
      e_we = st;
      e_be = st ? 4'(((1 << n) - 1) << o) : 4'hf;
      for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = st ? wd[8*(i % n) +: 8] : 8'h00;
      cap_ok = 1'b0; std_k = -1; ldv_n = 0; ldv_k = -1; stall_gap = 1'b0; err_c = 2'b00;
      k = 0; busy_m = 1'b0; code = 0;
      idle_exp();
      req_valid = 1'b1; req_opcode = op; req_addr = a; req_wdata = wd;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      cyc();
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_opcode = ops[$urandom_range(0, 7)];
      if (trap) begin
         idle_exp(); e_errv = 1'b1; e_code = 2'b01;
         cyc();
      end else begin
         busy_m = 1'b1;
         for (int c = 0; c < T; c++) begin
            e_ready = 1'b0; e_stall = 1'b1; e_req = (c <= g); e_ldv = 1'b0;
            e_std = st && c == g; e_errv = 1'b0;
            mem_gnt = (c == g);
            mem_rvalid = !st && c == g + d;
            mem_rdata = mem_rvalid ? rd : $urandom;
            cyc();
            if (st && c == g) break;
            if (!st && c == g + d) begin
               mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
               e_req = 1'b0; e_ldv = 1'b1; e_word = rd; e_shift = o; e_op = op;
               cyc();
               break;
            end
            if (c == T - 1) code = 2;
         end
         busy_m = 1'b0;
         idle_exp();
         mem_gnt = 1'b0; mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
         if (code != 0) begin e_errv = 1'b1; e_code = 2'(code); end
         cyc();
         mem_rvalid = 1'b0;
      end
   endtask

   initial begin
      int n4;
      logic seen;
      idle_exp();
      chk = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      ck("reset_req_ready", 32'(req_ready), 32'd1);
      ck("reset_mem_be", 32'(mem_be), 32'd0);
      rst_n = 1'b1;

      run(6'b101000, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 0);
      ck("sb_mem_addr", cap_addr, 32'h0000_1000);
      ck("sb_mem_be", 32'(cap_be), 32'h8);
      ck("sb_mem_wdata", cap_wd, 32'hA5A5_A5A5);
      ck("sb_mem_we", 32'(cap_we), 32'd1);
      ck("sb_st_done_cycle", 32'(std_k), 32'd1);

      run(6'b100101, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 2, 3);
      ck("lhu_pulses", 32'(ldv_n), 32'd1);
      ck("lhu_ld_word", ld_word, 32'hBEEF_1234);
      ck("lhu_ld_shift", 32'(ld_shift), 32'd2);
      ck("lhu_ld_opcode", 32'(ld_opcode), 32'h25);
      ck("lhu_stall_gap", 32'(stall_gap), 32'd0);

      run(6'b100011, 32'h0000_5000, 32'h0, 32'h1357_9BDF, 0, 0);
      ck("lw_fast_ld_cycle", 32'(ldv_k), 32'd2);

      run(6'b100011, 32'h0000_3001, 32'h0, 32'h0BAD_F00D, 1, 1);
`ifdef MISALIGN_TRAP_EN
      ck("mis_err_code", 32'(err_c), 32'd1);
      ck("mis_no_req", 32'(cap_ok), 32'd0);
`else
      ck("mis_mem_addr", cap_addr, 32'h0000_3000);
      ck("mis_ld_shift", 32'(ld_shift), 32'd0);
`endif

      for (int i = 0; i < 60; i++)
         run(ops[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
             $urandom_range(0, 9), $urandom_range(0, 9));

      idle_exp();
      req_opcode = 6'b100011; req_addr = 32'h0000_4000; req_valid4 = 1'b1;
      @(posedge clk); #1;
      req_valid4 = 1'b0;
      n4 = 0; seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (mem_req4) n4++;
         if (err_valid4) begin
            seen = 1'b1;
            ck("tmo_err_code", 32'(err_code4), 32'd2);
            ck("tmo_ready", 32'(req_ready4), 32'd1);
         end
      end
      ck("tmo_err_seen", 32'(seen), 32'd1);
      ck("tmo_req_cycles", 32'(n4), 32'd4);
      @(posedge clk); #1;
      mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      @(negedge clk);
      ck("late_rvalid_ld_valid", 32'(ld_valid4), 32'd0);
      ck("late_rvalid_stall", 32'(stall4), 32'd0);
      @(posedge clk); #1;

      chk = 1'b0;
      req_opcode = 6'b100011; req_addr = 32'h0000_0040; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      ck("wait_stall", 32'(stall), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      ck("rst_stall", 32'(stall), 32'd0);
      ck("rst_ready", 32'(req_ready), 32'd1);
      ck("rst_mem_be", 32'(mem_be), 32'd0);
      ck("rst_mem_addr", mem_addr, 32'd0);
      ck("rst_ld_word", ld_word, 32'd0);
      e_word = '0; e_shift = '0; e_op = '0;
      idle_exp();
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk = 1'b1;
      run(6'b100000, 32'h0000_0051, 32'h0, 32'h7766_5544, 1, 2);
      ck("post_rst_lb_pulses", 32'(ldv_n), 32'd1);
      ck("post_rst_lb_word", ld_word, 32'h7766_5544);
      ck("post_rst_lb_shift", 32'(ld_shift), 32'd1);

      chk = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory access controller for the MIPS MEM stage, sitting directly upstream of the load byte/halfword extraction stage. It accepts one load or store per transaction from the pipeline and drives a variable-latency word-addressed data memory through a request/grant/rvalid handshake. Stores get byte-lane enables and replicated write data. Loads return the raw 32-bit word with its byte offset and opcode to the extraction stage. The pipeline is stalled while a transaction is in flight.

## Interface
- TIMEOUT_CYCLES, 255: max cycles in ISSUE+WAIT before bus-timeout error (1..65535)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  MEM-stage request valid
- req_ready  out  1  high only in IDLE
- req_opcode  in  6  lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101, sb 101000, sh 101001, sw 101011
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- mem_req  out  1  memory request, held until mem_gnt
- mem_we  out  1  1 = write
- mem_be  out  4  byte enables, bit i = byte lane i
- mem_addr  out  32  word address, bits [1:0] always 00
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word
- ld_valid  out  1  one-cycle pulse, load result valid
- ld_word  out  32  registered raw read word
- ld_shift  out  2  byte offset of access
- ld_opcode  out  6  opcode of completed load
- st_done  out  1  one-cycle pulse, store granted
- stall  out  1  high whenever state != IDLE
- err_valid  out  1  one-cycle error pulse
- err_code  out  2  01 misaligned, 10 timeout

## Operation
- Accept on req_valid && req_ready with a memory opcode; other opcodes not accepted, no effect.
- On accept, register opcode, addr, wdata; drive mem_* from registers.
- Stores: sb → mem_be = 0001 << addr[1:0], mem_wdata = {4{wdata[7:0]}}; sh → 0011 (addr[1]=0) or 1100, {2{wdata[15:0]}}; sw → 1111, wdata; mem_we = 1.
- Loads: mem_we = 0, mem_be = 1111, mem_wdata = 0.
- FSM: IDLE → ISSUE on accept; ISSUE → IDLE on mem_gnt for stores (st_done pulse); ISSUE → WAIT on mem_gnt for loads; mem_gnt and mem_rvalid in the same cycle → RESP directly; WAIT → RESP on mem_rvalid (capture mem_rdata); RESP → IDLE, ld_valid = 1 for that one cycle.
- Timeout: 16-bit counter cleared on accept, increments each cycle in ISSUE/WAIT; when it equals TIMEOUT_CYCLES → drop mem_req, err_valid with err_code 10, return to IDLE. mem_rvalid arriving in IDLE is ignored.
- Misaligned: halfword with addr[0]=1, word with addr[1:0]≠00 (see Configuration).
- ld_shift = effective addr[1:0] after alignment handling.

## Timing
- Reset: state IDLE, every output 0 except req_ready = 1; counter 0; registers 0.
- Accept in cycle N → mem_req high from N+1; earliest store completion st_done at N+1 (same-cycle gnt); earliest load ld_valid at N+2.
- mem_addr/mem_be/mem_we/mem_wdata stable while mem_req high.
- ld_word/ld_shift/ld_opcode hold their values until next load completes.
- stall registered from state; new request accepted the cycle after RESP/store gnt.
- Reset asserted mid-transaction: immediate return to reset values; mem_req drops asynchronously.

## Configuration
- MISALIGN_TRAP_EN defined: misaligned access accepted, no memory request issued, err_valid pulse with code 01 in the cycle after accept, FSM stays IDLE.
- Undefined: offending low address bits cleared (lh @..1 → ..0, lw @..3 → ..0), access proceeds normally, no error.

## Test plan
- sb addr 0x1003 wdata 0x000000A5, gnt on first ISSUE cycle → mem_addr 0x1000, mem_be 1000, mem_wdata 0xA5A5A5A5, mem_we 1, st_done one cycle later than accept.
- lhu addr 0x2002, gnt after 2 cycles, rvalid 3 cycles later with 0xBEEF1234 → ld_valid one pulse, ld_word 0xBEEF1234, ld_shift 10, ld_opcode 100101; stall high throughout.
- lw with gnt and rvalid same cycle → ld_valid exactly 2 cycles after accept.
- TIMEOUT_CYCLES=4, no mem_gnt → mem_req drops after 4 cycles, err_code 10, back to IDLE; late rvalid ignored.
- lw addr 0x3001: with MISALIGN_TRAP_EN → no mem_req, err_code 01; without → mem_addr 0x3000, ld_shift 00.
- rst_n low while in WAIT → all outputs reset immediately, req_ready 1, next lb completes normally.
